// File: rtl/aes_round_tail.sv
// AES round tail: ShiftRows, MixColumns (bypassed on the final round) and AddRoundKey,
// with results held in a small valid/ready FIFO so downstream stalls never drop a beat.
module aes_round_tail #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             in_state,
  input  logic [127:0]             in_key,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_state,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [7:0]   a0, a1, a2, a3;
  logic [127:0] result;

  // Bytes are column-major: index k = 4*column + row.
  always_comb begin
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    result = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      sb[k] = in_state[127-8*k -: 8];
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int unsigned k = 0; k < 16; k++) begin
      result[127-8*k -: 8] = (in_last ? sr[k] : mc[k]) ^ in_key[127-8*k -: 8];
    end
  end

  logic [127:0]  mem_state [DEPTH];
  logic          mem_last  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_state = out_valid ? mem_state[rd_ptr] : '0;
  assign out_last  = out_valid ? mem_last[rd_ptr] : 1'b0;

  // Storage is written only on push, so X on idle inputs never reaches the entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_state[wr_ptr] <= result;
      mem_last[wr_ptr]  <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/aes_round_tail.md
Name: aes_round_tail

Overview:
- Registered stage directly downstream of the combinational S-box layer in the AES encryption datapath.
- Consumes the 128-bit SubBytes output and applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Holds results in a small FIFO with valid/ready handshakes on both sides, so back-pressure from the round-state register or output port never drops data.

Parameters:
- DEPTH, 2, result buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  upstream holds a valid SubBytes result.
- in_ready  output  1  stage can accept a beat this cycle.
- in_state  input  128  SubBytes output.
- in_key  input  128  round key for this beat.
- in_last  input  1  final round: bypass MixColumns.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts head this cycle.
- out_state  output  128  round result of the head entry.
- out_last  output  1  in_last of the head entry.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Byte mapping (FIPS-197 column-major): byte k = in_state[127-8k -: 8], row r = k mod 4, column c = k div 4.
- ShiftRows: s'(r,c) = s(r,(c+r) mod 4).
- MixColumns uses GF(2^8) with xtime reduction polynomial 0x11B. Per column: [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02].
- When in_last=1, the MixColumns result is replaced by the ShiftRows output.
- result = (MixColumns or bypass) XOR in_key, 128 bits, no carries.
- Transformation is combinational on the input side. The result and in_last are written into the FIFO on a push.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count < DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). out_state and out_last are driven from the head entry and are stable while out_valid=1 and out_ready=0.
- Latency: a beat pushed in cycle N is visible on out_valid/out_state in cycle N+1 when the buffer was empty. Otherwise it is visible after all older entries have popped.
- Ordering is strict FIFO. Read and write pointers wrap modulo DEPTH.
- Simultaneous push and pop with 0 < count < DEPTH: both happen and count is unchanged.
- Full (count=DEPTH): in_ready=0, and in_valid is ignored even if pop occurs in the same cycle.
- Empty: out_valid=0, and out_ready is ignored.
- flush=1: pointers and count go to 0 next edge. Any push or pop in that cycle is discarded. flush has priority over push and pop.
- Reset values (async assert, rst_n low): count=0, out_valid=0, in_ready=1 (combinational from count=0), out_state=0, out_last=0, pointers=0.
  - Storage contents need not reset, but out_state is forced to 0 while empty.
- Reset asserted mid-operation drops all entries immediately.
- No handshake occurs before the first clock edge after rst_n deasserts.
- in_state, in_key and in_last are don't-care when in_valid=0. X on them must not propagate to outputs.

Test Plan:
- Full round: in_state=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605, in_last=0, out_ready=1 -> next cycle out_valid=1, out_state=a49c7ff2689f352b6b5bea43026a5049, out_last=0.
- Final round bypass: same in_state, in_key=0, in_last=1 -> out_state=d4bf5d30e0b452aeb84111f11e2798e5, out_last=1.
- Back-pressure: out_ready=0, push 3 distinct beats on consecutive cycles -> after 2 pushes count=2 and in_ready=0. The third beat is held upstream and not lost. Raising out_ready drains all three in order.
- Streaming: in_valid=1 and out_ready=1 every cycle for 100 random beats -> one result per cycle, in order, matching a reference model; count stays at 1 after the first beat.
- Flush/reset: with count=2, pulse flush -> count=0 and out_valid=0 next cycle. Repeat with rst_n low mid-stream -> outputs zero immediately, without waiting for a clock edge.
- Simultaneous push/pop at count=1 with out_ready toggling randomly -> count never exceeds DEPTH, no duplicated or dropped beats, out_state stable while stalled.
